// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory: registered grants, owner lock, bounded hold.
// Optional build macro MEM_ARB_RR_EN selects round-robin tie-break from IDLE (default: port 0 wins).
//
// state | meaning
// IDLE  | no owner, memory bus parked at zero
// OWN0  | port 0 owns the memory (gnt0)
// OWN1  | port 1 owns the memory (gnt1)
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_HOLD   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic                  lock0,
   input  logic                  lock1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_write_en,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  busy
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   state_t            tie_pick;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic [HOLD_W-1:0] hold_inc;

`ifdef MEM_ARB_RR_EN
   logic last_owner;

   // Tie goes to the port that did not own the memory most recently.
   assign tie_pick = last_owner ? OWN0 : OWN1;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner <= 1'b1;
      end else if (state_nxt == OWN0) begin
         last_owner <= 1'b0;
      end else if (state_nxt == OWN1) begin
         last_owner <= 1'b1;
      end
   end
`else
   assign tie_pick = OWN0;
`endif

   assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // hold_nxt defaults to zero so every state change and IDLE clears the counter.
   always_comb begin
      state_nxt = state;
      hold_nxt  = '0;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               state_nxt = tie_pick;
            end else if (req0) begin
               state_nxt = OWN0;
            end else if (req1) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (!req0) begin
               state_nxt = req1 ? OWN1 : IDLE;
            end else if (!lock0 && req1 && (hold_cnt >= HOLD_MAX)) begin
               state_nxt = OWN1;
            end else begin
               hold_nxt = hold_inc;
            end
         end
         OWN1: begin
            if (!req1) begin
               state_nxt = req0 ? OWN0 : IDLE;
            end else if (!lock1 && req0 && (hold_cnt >= HOLD_MAX)) begin
               state_nxt = OWN0;
            end else begin
               hold_nxt = hold_inc;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign gnt0 = (state == OWN0);
   assign gnt1 = (state == OWN1);
   assign busy = gnt0 | gnt1;

   // Reset gates the write strobe so a write in flight never commits.
   assign mem_write_en = !reset && ((gnt0 && req0 && we0) || (gnt1 && req1 && we1));

   always_comb begin
      mem_address    = '0;
      mem_write_data = '0;
      if (gnt0) begin
         mem_address    = addr0;
         mem_write_data = wdata0;
      end else if (gnt1) begin
         mem_address    = addr1;
         mem_write_data = wdata1;
      end
   end

   assign rdata0 = gnt0 ? mem_read_data : '0;
   assign rdata1 = gnt1 ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against an owner/hold reference model.
// Honours MEM_ARB_RR_EN so the same bench covers both tie-break builds.
module tb_mem_port_arbiter;
   localparam int MH = 4;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       req [2];
   logic       we [2];
   logic       lock [2];
   logic [7:0] addr [2];
   logic [7:0] wdata [2];
   logic       gnt0, gnt1, mem_write_en, busy;
   logic [7:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];

   int total = 0;
   int bad = 0;
   int own, hold, last;
   bit mvalid = 1'b0;

   logic       wr_s;
   logic [7:0] wa_s, wd_s;

   mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(MH)) dut (
      .clk(clk), .reset(reset),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .lock0(lock[0]), .lock1(lock[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_address(mem_address), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic check_outputs();
      logic       e_we;
      logic [7:0] e_addr, e_wd;
      int         o;
      if (mvalid) begin
         o      = (own < 0) ? 0 : own;
         e_we   = (own >= 0) && req[o] && we[o] && !reset;
         e_addr = (own >= 0) ? addr[o] : 8'h00;
         e_wd   = (own >= 0) ? wdata[o] : 8'h00;
         chk("gnt0", gnt0, own == 0);
         chk("gnt1", gnt1, own == 1);
         chk("busy", busy, own >= 0);
         chk("excl", gnt0 & gnt1, 0);
         chk("wr_en", mem_write_en, e_we);
         chk("addr", mem_address, e_addr);
         chk("wdata", mem_write_data, e_wd);
         chk("rdata0", rdata0, (own == 0) ? ref_mem[addr[0]] : 8'h00);
         chk("rdata1", rdata1, (own == 1) ? ref_mem[addr[1]] : 8'h00);
      end
   endtask

   // Reference: who owns the memory next, from the arbitration rules.
   task automatic model_update();
      int x, y, nown;
      if (reset) begin
         own = -1; hold = 0; last = 1; mvalid = 1'b1;
      end else if (mvalid) begin
         if (own >= 0 && req[own] && we[own]) ref_mem[addr[own]] = wdata[own];
         nown = own;
         if (own < 0) begin
            hold = 0;
            if (req[0] && req[1]) nown = RR ? ((last == 0) ? 1 : 0) : 0;
            else if (req[0]) nown = 0;
            else if (req[1]) nown = 1;
         end else begin
            x = own; y = 1 - own;
            if (!req[x]) begin
               nown = req[y] ? y : -1;
               hold = 0;
            end else if (!lock[x] && req[y] && hold >= MH - 1) begin
               nown = y;
               hold = 0;
            end else begin
               hold = (hold + 1 > MH - 1) ? MH - 1 : hold + 1;
            end
         end
         if (nown >= 0 && nown != own) last = nown;
         own = nown;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      wr_s = mem_write_en; wa_s = mem_address; wd_s = mem_write_data;
      @(posedge clk);
      model_update();
      if (wr_s === 1'b1) mem[wa_s] = wd_s;
      #1;
   endtask

   task automatic idle_inputs();
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; lock[p] = 1'b0; addr[p] = 8'h00; wdata[p] = 8'h00;
      end
   endtask

   initial begin
      int n;
      logic [7:0] old;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();

      // single write from port 0
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'hA5;
      chk("t1_nogrant_yet", gnt0, 0);
      tick();
      chk("t1_gnt0", gnt0, 1);
      tick();
      chk("t1_mem10", mem[8'h10], 8'hA5);
      idle_inputs();
      tick(); tick();

      // unlocked owner preempted after MAX_HOLD grant cycles
      req[0] = 1'b1; addr[0] = 8'h10;
      tick();
      req[1] = 1'b1; addr[1] = 8'h20;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (gnt0) n++;
         if (gnt1) break;
         tick();
      end
      chk("t2_hold_cycles", n, MH);
      chk("t2_gnt1", gnt1, 1);
      idle_inputs();
      tick(); tick();

      // locked owner keeps the memory, then hands over without a bubble
      req[0] = 1'b1; lock[0] = 1'b1; req[1] = 1'b1; addr[1] = 8'h21;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("t3_locked", gnt0, 1);
         tick();
      end
      req[0] = 1'b0; lock[0] = 1'b0;
      tick();
      chk("t3_handover", gnt1, 1);
      idle_inputs();
      tick(); tick();

      // tie-break from IDLE twice
      req[0] = 1'b1; req[1] = 1'b1;
      tick();
      chk("t4_tie1", gnt0, 1);
      idle_inputs();
      tick(); tick();
      req[0] = 1'b1; req[1] = 1'b1;
      tick();
      chk("t4_tie2", gnt1, RR ? 1 : 0);
      idle_inputs();
      tick(); tick();

      // reset during a port 1 write
      old = mem[8'h33];
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h33; wdata[1] = ~old;
      tick();
      chk("t5_gnt1", gnt1, 1);
      reset = 1'b1;
      tick();
      chk("t5_mem_kept", mem[8'h33], old);
      chk("t5_gnt1_off", gnt1, 0);
      chk("t5_busy_off", busy, 0);
      reset = 1'b0;
      idle_inputs();
      tick();

      // two-byte locked fetch with port 1 pending
      req[0] = 1'b1; lock[0] = 1'b1; addr[0] = 8'h00; req[1] = 1'b1; addr[1] = 8'h40;
      tick();
      chk("t6_gnt0", gnt0, 1);
      chk("t6_byte0", rdata0, mem[0]);
      tick();
      addr[0] = 8'h01;
      #1;
      chk("t6_gnt0_b", gnt0, 1);
      chk("t6_byte1", rdata0, mem[1]);
      tick();
      req[0] = 1'b0; lock[0] = 1'b0;
      tick();
      chk("t6_handover", gnt1, 1);
      idle_inputs();
      tick();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 4) == 0) req[p] = ~req[p];
            lock[p]  = ($urandom_range(0, 3) == 0);
            we[p]    = 1'($urandom);
            addr[p]  = 8'($urandom_range(0, 15));
            wdata[p] = 8'($urandom);
         end
         reset = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
